// File: rtl/pmem_responder.sv
// pmem_responder: single-outstanding, fixed-latency slave for the 256-bit
// line-wide pmem interface. A request is latched in IDLE, counted down in
// BUSY, and completed with a one-cycle registered pmem_resp pulse that starts
// exactly LATENCY edges after the accepting edge.
module pmem_responder #(
   parameter int LINE_IDX_BITS = 10,
   parameter int LATENCY       = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [31:0]  pmem_address,
   input  logic [255:0] pmem_wdata,
   output logic         pmem_resp,
   output logic         pmem_error,
   output logic [255:0] pmem_rdata
);

   localparam int NUM_LINES = 2 ** LINE_IDX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   state_e       state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         rd_q, rd_d;
   logic         wr_q, wr_d;
   logic [26:0]  line_q, line_d;
   logic [255:0] wdata_q, wdata_d;
   logic         resp_q, resp_d;
   logic         error_q, error_d;
   logic [255:0] rdata_q, rdata_d;

   logic [255:0]             mem [NUM_LINES];
   logic [255:0]             mem_rd_q;
   logic [LINE_IDX_BITS-1:0] mem_idx;
   logic                     req_err;
   logic                     mem_we;
   logic                     unused_addr_offset;

   // Byte offset inside the line carries no meaning for a line-wide slave.
   assign unused_addr_offset = ^pmem_address[4:0];

   // Latched request is illegal if both ops were requested or the line is
   // beyond the array; either way the array is left untouched.
   assign req_err = (rd_q && wr_q) || (line_q[26:LINE_IDX_BITS] != '0);

   // In IDLE the incoming address steers the read port so that even a
   // LATENCY==1 transaction has its line data ready one edge later.
   assign mem_idx = (state_q == IDLE) ? pmem_address[5 +: LINE_IDX_BITS]
                                      : line_q[LINE_IDX_BITS-1:0];

   // The array commits on the same edge that raises pmem_resp.
   assign mem_we = (state_q == RESP) && wr_q && !req_err;

   // Next-state, counter and registered-output computation.
   always_comb begin
      // NOTE: every _d gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      line_d  = line_q;
      wdata_d = wdata_q;
      resp_d  = 1'b0;
      error_d = 1'b0;
      rdata_d = rdata_q;

      case (state_q)
         IDLE: begin
            if (pmem_read || pmem_write) begin
               rd_d    = pmem_read;
               wr_d    = pmem_write;
               line_d  = pmem_address[31:5];
               wdata_d = pmem_wdata;
               cnt_d   = 8'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
            resp_d  = 1'b1;
            error_d = req_err;
            if (req_err) begin
               rdata_d = '0;
            end else if (rd_q) begin
               rdata_d = mem_rd_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         line_q  <= '0;
         wdata_q <= '0;
         resp_q  <= 1'b0;
         error_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         line_q  <= line_d;
         wdata_q <= wdata_d;
         resp_q  <= resp_d;
         error_q <= error_d;
         rdata_q <= rdata_d;
      end
   end

   // Line array with a registered read port; a write is suppressed under reset.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset so it maps onto block RAM.
      if (mem_we && !rst) begin
         mem[line_q[LINE_IDX_BITS-1:0]] <= wdata_q;
      end
      mem_rd_q <= mem[mem_idx];
   end

   assign pmem_resp  = resp_q;
   assign pmem_error = error_q;
   assign pmem_rdata = rdata_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: directed and random line requests
// against a queue/associative-array memory model, with a scoreboard monitor
// that checks response timing, error flag and read data.
module tb_pmem_responder;

   localparam int LAT = 8;
   localparam int IDX = 10;

   typedef struct {
      int           due;
      logic         err;
      logic [255:0] rdata;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic         pmem_resp, pmem_error;
   logic [255:0] pmem_rdata;

   logic         l1_read, l1_write;
   logic [31:0]  l1_address;
   logic [255:0] l1_wdata;
   logic         l1_resp, l1_error;
   logic [255:0] l1_rdata;

   int           vectors = 0;
   int           miscompares = 0;
   int           cyc = 0;
   exp_t         sb[$];
   logic [255:0] mem_m [int];
   logic [255:0] last_rdata = '0;
   logic [255:0] pattern;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pmem_responder #(.LINE_IDX_BITS(IDX), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_error(pmem_error), .pmem_rdata(pmem_rdata)
   );

   pmem_responder #(.LINE_IDX_BITS(4), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .pmem_read(l1_read), .pmem_write(l1_write),
      .pmem_address(l1_address), .pmem_wdata(l1_wdata),
      .pmem_resp(l1_resp), .pmem_error(l1_error), .pmem_rdata(l1_rdata)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] model_rd(input int line);
      return mem_m.exists(line) ? mem_m[line] : '0;
   endfunction

   // Issue one request at the current negedge, track expectations, and return
   // at the negedge of the response cycle with the request still asserted.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] data);
      exp_t e;
      int   line;
      bit   got;
      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = addr;
      pmem_wdata   = data;
      @(negedge clk);
      line  = int'(addr[31:5]);
      e.due = cyc + LAT;
      e.err = (rd && wr) || (line >= (1 << IDX));
      if (e.err)   last_rdata = '0;
      else if (rd) last_rdata = model_rd(line);
      else         mem_m[line] = data;
      e.rdata = last_rdata;
      sb.push_back(e);
      // Scramble address/data while busy; the latched request must win.
      got = 1'b0;
      for (int k = 0; k < LAT + 4; k++) begin
         if (pmem_resp) begin
            got = 1'b1;
            break;
         end
         pmem_address = $urandom;
         pmem_wdata   = {8{$urandom}};
         @(negedge clk);
      end
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL resp_timeout: no pmem_resp within %0d cycles", LAT + 4);
      end
   endtask

   task automatic idle(input int n);
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Directed transaction on the LATENCY=1 instance: resp 0, then 1, then 0.
   task automatic l1_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] data, input logic [255:0] exp_rdata);
      l1_read    = rd;
      l1_write   = wr;
      l1_address = addr;
      l1_wdata   = data;
      @(negedge clk);
      check("l1_resp_after_accept", 256'(l1_resp), 256'(1'b0));
      @(negedge clk);
      check("l1_resp_pulse", 256'(l1_resp), 256'(1'b1));
      check("l1_error", 256'(l1_error), 256'(1'b0));
      check("l1_rdata", l1_rdata, exp_rdata);
      l1_read  = 1'b0;
      l1_write = 1'b0;
      @(negedge clk);
      check("l1_resp_one_cycle", 256'(l1_resp), 256'(1'b0));
   endtask

   // Scoreboard monitor: every response must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && pmem_resp) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: pmem_resp at cycle %0d with nothing outstanding", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_cycle", 256'(cyc), 256'(e.due));
            check("resp_error", 256'(pmem_error), 256'(e.err));
            check("resp_rdata", pmem_rdata, e.rdata);
         end
      end else if (!rst && pmem_error) begin
         vectors++;
         miscompares++;
         $display("FAIL error_without_resp: pmem_error=1 at cycle %0d", cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          line;
      int          op;
      logic [31:0] addr;
      logic [255:0] old2;

      rst = 1'b1;
      pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
      l1_read = 1'b0; l1_write = 1'b0; l1_address = '0; l1_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_resp", 256'(pmem_resp), 256'(1'b0));
      check("reset_error", 256'(pmem_error), 256'(1'b0));
      check("reset_rdata", pmem_rdata, '0);

      // Preload every line the random phase touches so no read sees X.
      for (int i = 0; i < 8; i++) issue(1'b0, 1'b1, 32'(i) << 5, {8{$urandom}});
      issue(1'b0, 1'b1, 32'(1023) << 5, {8{$urandom}});

      // Line write/read, offset bits ignored.
      pattern = {16{16'hA5A5}};
      issue(1'b0, 1'b1, 32'h0000_0040, pattern);
      issue(1'b1, 1'b0, 32'h0000_0040, '0);
      issue(1'b1, 1'b0, 32'h0000_005F, '0);
      // Out of range read, then line 0 unaffected.
      issue(1'b1, 1'b0, 32'h0010_0000, '0);
      issue(1'b1, 1'b0, 32'h0000_0000, '0);
      // Out of range write must not alias onto line 0.
      issue(1'b0, 1'b1, 32'h0000_8000, {8{32'hDEAD_BEEF}});
      issue(1'b1, 1'b0, 32'h0000_0000, '0);
      // Read and write together: error, array unchanged.
      issue(1'b1, 1'b1, 32'h0000_0040, {8{32'h1234_5678}});
      issue(1'b1, 1'b0, 32'h0000_0040, '0);
      idle(2);

      // Reset during BUSY aborts a write with no response.
      old2 = model_rd(2);
      pmem_read = 1'b0; pmem_write = 1'b1;
      pmem_address = 32'h0000_0040; pmem_wdata = {8{32'hCAFE_F00D}};
      @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      pmem_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_rdata = '0;
      check("abort_resp", 256'(pmem_resp), 256'(1'b0));
      check("abort_error", 256'(pmem_error), 256'(1'b0));
      check("abort_rdata", pmem_rdata, '0);
      idle(LAT + 3);
      check("abort_old_data_model", model_rd(2), old2);
      issue(1'b1, 1'b0, 32'h0000_0040, '0);

      // Random back-to-back traffic.
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 9));
         case ($urandom_range(0, 9))
            0:       line = 1023;
            1:       line = 1024 + int'($urandom_range(0, 5000));
            default: line = int'($urandom_range(0, 7));
         endcase
         addr = {27'(line), 5'($urandom)};
         issue(op < 5, op >= 5 && op < 9 ? 1'b1 : (op == 9), addr, {8{$urandom}});
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(LAT + 3);
      check("scoreboard_drained", 256'(sb.size()), 256'(0));

      // LATENCY=1 build: write a line, then read it back.
      l1_txn(1'b0, 1'b1, 32'h0000_0020, pattern, '0);
      l1_txn(1'b1, 1'b0, 32'h0000_0020, '0, pattern);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
